// File: rtl/ec_pkg.sv
// Shared error-code and compare-result encodings for the multi-lane sign-select stage,
// plus the saturating popcount used to grade how many lanes disagree.
package ec_pkg;

  localparam logic [1:0] EC_NONE  = 2'd0;
  localparam logic [1:0] EC_COR   = 2'd1;
  localparam logic [1:0] EC_UNCOR = 2'd2;
  localparam logic [1:0] EC_MAL   = 2'd3;

  localparam logic [1:0] CMP_LO = 2'd0;
  localparam logic [1:0] CMP_HI = 2'd2;

  // Only "none / one / several" matters, so the count stops at 2.
  function automatic logic [1:0] popcount_sat2(input logic [31:0] vec);
    logic [1:0] cnt;
    cnt = 2'd0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i] && (cnt != 2'd2)) cnt = cnt + 2'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ec_lane_decode.sv
// Combinational decode of one lane's pair of range-compare results into
// select / normal-error / abnormal flags.
module ec_lane_decode
  import ec_pkg::*;
(
  input  logic [1:0] i_sign_a,
  input  logic [1:0] i_sign_b,
  output logic       o_sel,
  output logic       o_norm,
  output logic       o_abnorm
);

  assign o_sel = ((i_sign_a == CMP_LO) && (i_sign_b == CMP_LO)) ||
                 ((i_sign_a == CMP_HI) && (i_sign_b == CMP_HI));
  assign o_norm = (i_sign_a != i_sign_b);
  // Legal compare results are even; an odd code on either side means a broken comparator.
  assign o_abnorm = i_sign_a[0] | i_sign_b[0];

endmodule

// File: rtl/ec_multi_sign_select.sv
// Multi-lane pipelined sign-select with word error code, early flags and saturating counters.
// Optional first-error capture outputs are built when EC_ERR_CAPTURE_EN is defined.
module ec_multi_sign_select
  import ec_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_DIGITS = 8,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [2*NUM_DIGITS-1:0]          sign_in_A,
  input  logic [2*NUM_DIGITS-1:0]          sign_in_B,
  input  logic [DATA_WIDTH*NUM_DIGITS-1:0] in_Y,
  input  logic [DATA_WIDTH*NUM_DIGITS-1:0] in_cor,
  input  logic                             clr_counts,
  output logic                             out_valid,
  output logic [DATA_WIDTH*NUM_DIGITS-1:0] out,
  output logic [1:0]                       error,
  output logic [NUM_DIGITS-1:0]            lane_err,
  output logic                             cor_err_stg1,
  output logic                             mal_err_stg1,
  output logic [CNT_WIDTH-1:0]             cor_count,
  output logic [CNT_WIDTH-1:0]             mal_count
`ifdef EC_ERR_CAPTURE_EN
  ,
  output logic                             cap_valid,
  output logic [1:0]                       cap_code,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] cap_lane
`endif
);

  localparam int WW = DATA_WIDTH * NUM_DIGITS;
  localparam int NS = PIPE_DEPTH - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_DIGITS-1:0] w_sel;
  logic [NUM_DIGITS-1:0] w_norm;
  logic [NUM_DIGITS-1:0] w_abnorm;
  logic [NUM_DIGITS-1:0] w_norm_v;
  logic [1:0]            w_code;
  logic [WW-1:0]         w_mux;

  logic [WW-1:0]         r_y    [NS];
  logic [WW-1:0]         r_cor  [NS];
  logic [NUM_DIGITS-1:0] r_sel  [NS];
  logic [NUM_DIGITS-1:0] r_norm [NS];
  logic [1:0]            r_code [NS];
  logic                  r_vld  [NS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lane
      ec_lane_decode u_dec (
        .i_sign_a (sign_in_A[2*gi +: 2]),
        .i_sign_b (sign_in_B[2*gi +: 2]),
        .o_sel    (w_sel[gi]),
        .o_norm   (w_norm[gi]),
        .o_abnorm (w_abnorm[gi])
      );
      assign w_mux[DATA_WIDTH*gi +: DATA_WIDTH] = r_sel[NS-1][gi] ?
                                                  r_cor[NS-1][DATA_WIDTH*gi +: DATA_WIDTH] :
                                                  r_y[NS-1][DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    w_code = EC_NONE;
    if (|w_abnorm) begin
      w_code = EC_MAL;
    end else begin
      case (popcount_sat2(32'(w_norm)))
        2'd2:    w_code = EC_UNCOR;
        2'd1:    w_code = EC_COR;
        default: w_code = EC_NONE;
      endcase
    end
    if (!in_valid) w_code = EC_NONE;
  end

  // Bubbles carry a zero code and zero lane flags so they never count or capture.
  assign w_norm_v = in_valid ? w_norm : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NS; s++) begin
        r_y[s]    <= '0;
        r_cor[s]  <= '0;
        r_sel[s]  <= '0;
        r_norm[s] <= '0;
        r_code[s] <= EC_NONE;
        r_vld[s]  <= 1'b0;
      end
    end else begin
      r_y[0]    <= in_Y;
      r_cor[0]  <= in_cor;
      r_sel[0]  <= w_sel;
      r_norm[0] <= w_norm_v;
      r_code[0] <= w_code;
      r_vld[0]  <= in_valid;
      for (int s = 1; s < NS; s++) begin
        r_y[s]    <= r_y[s-1];
        r_cor[s]  <= r_cor[s-1];
        r_sel[s]  <= r_sel[s-1];
        r_norm[s] <= r_norm[s-1];
        r_code[s] <= r_code[s-1];
        r_vld[s]  <= r_vld[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      error     <= EC_NONE;
      lane_err  <= '0;
    end else begin
      out_valid <= r_vld[NS-1];
      out       <= w_mux;
      error     <= r_code[NS-1];
      lane_err  <= r_norm[NS-1];
    end
  end

  assign cor_err_stg1 = (r_code[NS-1] == EC_COR);
  assign mal_err_stg1 = r_code[NS-1][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cor_count <= '0;
      mal_count <= '0;
    end else if (clr_counts) begin
      cor_count <= '0;
      mal_count <= '0;
    end else begin
      if (out_valid && (error == EC_COR) && (cor_count != CNT_MAX))
        cor_count <= cor_count + 1'b1;
      if (out_valid && error[1] && (mal_count != CNT_MAX))
        mal_count <= mal_count + 1'b1;
    end
  end

`ifdef EC_ERR_CAPTURE_EN
  localparam int CAP_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  logic [CAP_W-1:0] w_first_lane;

  // Descending scan so the lowest flagged lane is the one left standing.
  always_comb begin
    w_first_lane = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (lane_err[i]) w_first_lane = CAP_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_code  <= EC_NONE;
      cap_lane  <= '0;
    end else if (clr_counts) begin
      cap_valid <= 1'b0;
      cap_code  <= EC_NONE;
      cap_lane  <= '0;
    end else if (!cap_valid && out_valid && (error != EC_NONE)) begin
      cap_valid <= 1'b1;
      cap_code  <= error;
      cap_lane  <= w_first_lane;
    end
  end
`endif

endmodule

// File: tb/tb_ec_multi_sign_select.sv
// Scoreboard bench: two DUTs (depth 2 / 16-bit counters and depth 4 / 2-bit counters)
// share one randomized stimulus stream; a negedge monitor checks each against a spec model.
module tb_ec_multi_sign_select;

  localparam int DW = 18;
  localparam int ND = 8;
  localparam int WW = DW * ND;

  typedef struct {
    logic [WW-1:0] out;
    logic [1:0]    code;
    logic [ND-1:0] le;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          clr_counts = 1'b0;
  logic [2*ND-1:0] s_a = '0;
  logic [2*ND-1:0] s_b = '0;
  logic [WW-1:0] i_y = '0;
  logic [WW-1:0] i_c = '0;

  logic          v0, v1, cf0, cf1, mf0, mf1;
  logic [WW-1:0] o0, o1;
  logic [1:0]    e0, e1;
  logic [ND-1:0] le0, le1;
  logic [15:0]   cc0, mc0;
  logic [1:0]    cc1, mc1;
`ifdef EC_ERR_CAPTURE_EN
  logic          capv0, capv1;
  logic [1:0]    capc0, capc1;
  logic [2:0]    capl0, capl1;
  logic          m_capv;
  logic [1:0]    m_capc;
  logic [2:0]    m_capl;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   mcor[2];
  int   mmal[2];
  logic pcf[2];
  logic pmf[2];

  ec_multi_sign_select #(.DATA_WIDTH(DW), .NUM_DIGITS(ND), .PIPE_DEPTH(2), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sign_in_A(s_a), .sign_in_B(s_b),
    .in_Y(i_y), .in_cor(i_c), .clr_counts(clr_counts), .out_valid(v0), .out(o0),
    .error(e0), .lane_err(le0), .cor_err_stg1(cf0), .mal_err_stg1(mf0),
    .cor_count(cc0), .mal_count(mc0)
`ifdef EC_ERR_CAPTURE_EN
    , .cap_valid(capv0), .cap_code(capc0), .cap_lane(capl0)
`endif
  );

  ec_multi_sign_select #(.DATA_WIDTH(DW), .NUM_DIGITS(ND), .PIPE_DEPTH(4), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sign_in_A(s_a), .sign_in_B(s_b),
    .in_Y(i_y), .in_cor(i_c), .clr_counts(clr_counts), .out_valid(v1), .out(o1),
    .error(e1), .lane_err(le1), .cor_err_stg1(cf1), .mal_err_stg1(mf1),
    .cor_count(cc1), .mal_count(mc1)
`ifdef EC_ERR_CAPTURE_EN
    , .cap_valid(capv1), .cap_code(capc1), .cap_lane(capl1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cyc %0d: got %0h, expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // Reference model written straight from the lane and word rules.
  function automatic exp_t model(input logic [2*ND-1:0] a, input logic [2*ND-1:0] b,
                                 input logic [WW-1:0] y, input logic [WW-1:0] c);
    exp_t e;
    int   n_norm;
    bit   any_ab;
    int   ai, bi;
    n_norm = 0;
    any_ab = 0;
    e.le = '0;
    e.out = '0;
    e.due = 0;
    for (int i = 0; i < ND; i++) begin
      ai = int'(a[2*i +: 2]);
      bi = int'(b[2*i +: 2]);
      if (ai != bi) begin
        n_norm++;
        e.le[i] = 1'b1;
      end
      if (ai == 1 || ai == 3 || bi == 1 || bi == 3) any_ab = 1;
      if ((ai == 0 && bi == 0) || (ai == 2 && bi == 2)) e.out[DW*i +: DW] = c[DW*i +: DW];
      else e.out[DW*i +: DW] = y[DW*i +: DW];
    end
    if (any_ab) e.code = 2'd3;
    else if (n_norm >= 2) e.code = 2'd2;
    else if (n_norm == 1) e.code = 2'd1;
    else e.code = 2'd0;
    return e;
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic mon(input int k, input logic v, input logic [WW-1:0] o, input logic [1:0] err,
                     input logic [ND-1:0] le, input logic cf, input logic mf,
                     input logic [15:0] cc, input logic [15:0] mc);
    exp_t e;
    bit   have;
    have = 0;
    if (reset) begin
      if (k == 0) q0.delete(); else q1.delete();
      mcor[k] = 0;
      mmal[k] = 0;
      pcf[k] = 1'b0;
      pmf[k] = 1'b0;
`ifdef EC_ERR_CAPTURE_EN
      if (k == 0) begin m_capv = 1'b0; m_capc = 2'd0; m_capl = 3'd0; end
`endif
      return;
    end
    chk("cor_count", k, cc, mcor[k]);
    chk("mal_count", k, mc, mmal[k]);
`ifdef EC_ERR_CAPTURE_EN
    if (k == 0) begin
      chk("cap_valid", k, capv0, m_capv);
      chk("cap_code", k, capc0, m_capc);
      chk("cap_lane", k, capl0, m_capl);
    end
`endif
    while (qsize(k) > 0 && qfront(k).due < cyc) begin
      chk("missing_output", k, 0, 1);
      qpop(k);
    end
    if (v) begin
      if (qsize(k) == 0) begin
        chk("unexpected_valid", k, 1, 0);
      end else begin
        e = qfront(k);
        qpop(k);
        have = 1;
        chk("latency", k, cyc, e.due);
        chk("out", k, o, e.out);
        chk("error", k, err, e.code);
        chk("lane_err", k, le, e.le);
        chk("cor_err_stg1", k, pcf[k], e.code == 2'd1);
        chk("mal_err_stg1", k, pmf[k], e.code[1]);
      end
    end else begin
      chk("bubble_error", k, err, 0);
      chk("bubble_lane_err", k, le, 0);
      chk("bubble_stg1_flags", k, {pcf[k], pmf[k]}, 0);
    end
    if (clr_counts) begin
      mcor[k] = 0;
      mmal[k] = 0;
    end else if (have) begin
      if (e.code == 2'd1 && mcor[k] < cmax(k)) mcor[k]++;
      if (e.code[1] && mmal[k] < cmax(k)) mmal[k]++;
    end
`ifdef EC_ERR_CAPTURE_EN
    if (k == 0) begin
      if (clr_counts) begin
        m_capv = 1'b0; m_capc = 2'd0; m_capl = 3'd0;
      end else if (have && !m_capv && e.code != 2'd0) begin
        m_capv = 1'b1;
        m_capc = e.code;
        m_capl = 3'd0;
        for (int i = ND - 1; i >= 0; i--) if (e.le[i]) m_capl = 3'(i);
      end
    end
`endif
    pcf[k] = cf;
    pmf[k] = mf;
  endtask

  always @(negedge clk) begin
    mon(0, v0, o0, e0, le0, cf0, mf0, cc0, mc0);
    mon(1, v1, o1, e1, le1, cf1, mf1, {14'b0, cc1}, {14'b0, mc1});
  end

  task automatic zero_check();
    chk("rst_out_valid", 0, v0, 0);  chk("rst_out_valid", 1, v1, 0);
    chk("rst_out", 0, o0, 0);        chk("rst_out", 1, o1, 0);
    chk("rst_error", 0, e0, 0);      chk("rst_error", 1, e1, 0);
    chk("rst_lane_err", 0, le0, 0);  chk("rst_lane_err", 1, le1, 0);
    chk("rst_flags", 0, {cf0, mf0}, 0);
    chk("rst_flags", 1, {cf1, mf1}, 0);
    chk("rst_counts", 0, {cc0, mc0}, 0);
    chk("rst_counts", 1, {cc1, mc1}, 0);
`ifdef EC_ERR_CAPTURE_EN
    chk("rst_cap_valid", 0, capv0, 0);
    chk("rst_cap_valid", 1, capv1, 0);
`endif
  endtask

  task automatic gen(output logic [2*ND-1:0] a, output logic [2*ND-1:0] b,
                     output logic [WW-1:0] y, output logic [WW-1:0] c);
    int r;
    logic [1:0] lo;
    for (int i = 0; i < ND; i++) begin
      r = $urandom_range(0, 99);
      lo = $urandom_range(0, 1) ? 2'd2 : 2'd0;
      if (r < 92) begin
        a[2*i +: 2] = lo;
        b[2*i +: 2] = lo;
      end else if (r < 98) begin
        a[2*i +: 2] = lo;
        b[2*i +: 2] = 2'd2 - lo;
      end else begin
        a[2*i +: 2] = 2'($urandom_range(0, 3));
        b[2*i +: 2] = $urandom_range(0, 1) ? 2'd1 : 2'd3;
      end
      y[DW*i +: DW] = DW'($urandom);
      c[DW*i +: DW] = DW'($urandom);
    end
  endtask

  task automatic send(input logic v, input logic clr, input logic [2*ND-1:0] a,
                      input logic [2*ND-1:0] b, input logic [WW-1:0] y, input logic [WW-1:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    clr_counts = clr;
    s_a = a;
    s_b = b;
    i_y = y;
    i_c = c;
    if (v) begin
      e = model(a, b, y, c);
      e.due = cyc + 2;
      q0.push_back(e);
      e.due = cyc + 4;
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    logic [2*ND-1:0] a, b;
    logic [WW-1:0]   y, c;
    for (int i = 0; i < n; i++) begin
      gen(a, b, y, c);
      send(1'b0, 1'b0, a, b, y, c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*ND-1:0] a, b;
    logic [WW-1:0]   y, c;

    repeat (3) @(posedge clk);
    #1;
    zero_check();
    #1 reset = 1'b0;

    // Clean word: every lane takes the corrected digit.
    a = '0; b = '0;
    for (int i = 0; i < ND; i++) begin
      y[DW*i +: DW] = DW'(i);
      c[DW*i +: DW] = DW'(i + 100);
    end
    send(1'b1, 1'b0, a, b, y, c);
    idle(3);

    // Single-lane error on lane 3.
    b[7:6] = 2'd2;
    send(1'b1, 1'b0, a, b, y, c);
    idle(3);

    // Two disagreeing lanes, then an abnormal compare on lane 2.
    a = '0; b = '0;
    b[3:2] = 2'd2;
    a[11:10] = 2'd2;
    send(1'b1, 1'b0, a, b, y, c);
    a = '0; b = '0;
    a[5:4] = 2'd1;
    send(1'b1, 1'b0, a, b, y, c);
    idle(5);

    // Alternating valid/bubble error words.
    for (int i = 0; i < 20; i++) begin
      gen(a, b, y, c);
      a[1:0] = 2'd0;
      b[1:0] = 2'd2;
      send((i % 2) == 0, 1'b0, a, b, y, c);
    end
    idle(5);

    // Saturation, then a clear landing on a valid corrected output.
    for (int i = 0; i < 10; i++) begin
      gen(a, b, y, c);
      a = '0; b = '0;
      b[7:6] = 2'd2;
      send(1'b1, i == 7, a, b, y, c);
    end
    idle(5);

    for (int i = 0; i < 300; i++) begin
      gen(a, b, y, c);
      send($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, a, b, y, c);
    end

    // Asynchronous reset between edges with words in flight.
    for (int i = 0; i < 3; i++) begin
      gen(a, b, y, c);
      b[1:0] = 2'd2; a[1:0] = 2'd0;
      send(1'b1, 1'b0, a, b, y, c);
    end
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    clr_counts = 1'b0;
    #1;
    zero_check();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      gen(a, b, y, c);
      send(1'b1, 1'b0, a, b, y, c);
    end
    idle(8);

    chk("drain_queue", 0, q0.size(), 0);
    chk("drain_queue", 1, q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ec_multi_sign_select.md
Name: ec_multi_sign_select

Overview:
- Multi-lane, parametrised successor to the two-stage single-digit sign-select stage.
- Takes NUM_DIGITS residue digits per word, each with an uncorrected value, a corrected value and a pair of 2-bit range-comparison results.
- Per digit, it selects the corrected or the uncorrected digit through a configurable-depth pipeline.
- It also produces a word-level error code, stage-(N-1) early flags and saturating corrected/malfunction event counters.
- It sits at the end of the TPU error-correction pipe, feeding the result register file.

Parameters:
- DATA_WIDTH, 18, width of one residue digit.
- NUM_DIGITS, 8, number of digit lanes per word (1..32).
- PIPE_DEPTH, 2, input-to-output latency in cycles (minimum 2).
- CNT_WIDTH, 16, width of each event counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  word on the inputs is valid this cycle.
- sign_in_A  in  2*NUM_DIGITS  positive-range compare result; lane i is bits [2i+1:2i].
- sign_in_B  in  2*NUM_DIGITS  negative-range compare result; same packing.
- in_Y  in  DATA_WIDTH*NUM_DIGITS  uncorrected digits; lane i is bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- in_cor  in  DATA_WIDTH*NUM_DIGITS  corrected digits; same packing.
- clr_counts  in  1  synchronous clear of both counters.
- out_valid  out  1  out/error are valid.
- out  out  DATA_WIDTH*NUM_DIGITS  selected digits.
- error  out  2  word code: 00 none, 01 corrected, 10 uncorrectable, 11 malfunction.
- lane_err  out  NUM_DIGITS  per-lane err_norm, aligned with out.
- cor_err_stg1  out  1  word code is 01, one cycle before out_valid.
- mal_err_stg1  out  1  word code is 1x, one cycle before out_valid.
- cor_count  out  CNT_WIDTH  saturating count of valid words with code 01.
- mal_count  out  CNT_WIDTH  saturating count of valid words with code 10 or 11.

Behaviour:
- Per-lane decode, combinational on the inputs:
  - sel_i = (A_i==0 && B_i==0) || (A_i==2 && B_i==2).
  - norm_i = (A_i != B_i).
  - abnorm_i = A_i or B_i is in {1, 3}.
- Word code, in priority order:
  - any abnorm_i gives 11;
  - else popcount(norm) >= 2 gives 10;
  - else popcount(norm) == 1 gives 01;
  - else 00.
  - When in_valid = 0, the code and norm vector are forced to 0.
- Stage 1 registers in_Y, in_cor, the sel vector, the norm vector, the code and in_valid.
- Stages 2..PIPE_DEPTH-1 are pure delay registers.
- The final stage registers the mux result per lane (sel_i = 1 takes in_cor, else in_Y) together with the aligned code, lane_err and valid.
- Latency is exactly PIPE_DEPTH cycles for out, error, lane_err and out_valid.
- cor_err_stg1 and mal_err_stg1 are taken from the stage-(PIPE_DEPTH-1) code register, so they lead by exactly one cycle.
- The data path has no enable: registers load every cycle, and invalid words flow through as bubbles with out_valid = 0 and error = 00. The design is fully pipelined, with no backpressure.
- Counters:
  - Increment on out_valid with the matching code.
  - Hold at 2^CNT_WIDTH-1; no wrap.
  - clr_counts has priority over increment in the same cycle (result 0).
- Reset clears every register and output to 0 immediately, regardless of clk. A word in flight at reset is discarded, and out_valid stays 0 until a new word has traversed PIPE_DEPTH stages.

Optional Feature:
- Macro EC_ERR_CAPTURE_EN.
- When defined, it adds outputs cap_valid (1 bit), cap_code (2 bits) and cap_lane ($clog2(NUM_DIGITS) bits, minimum 1).
  - On the first out_valid word with a non-zero code after reset or clr_counts, the block latches the code and the lowest-index lane with lane_err = 1 (0 if none), and sets cap_valid.
  - These values are held until clr_counts or reset.
  - A capture and a clear in the same cycle: the clear wins.
- When undefined, these ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Package ec_pkg holds:
  - the error-code constants EC_NONE = 2'd0, EC_COR = 2'd1, EC_UNCOR = 2'd2, EC_MAL = 2'd3;
  - the compare-result encodings CMP_LO = 2'd0 and CMP_HI = 2'd2;
  - a popcount-saturate-at-2 function.
- Natural sub-module ec_lane_decode: pure combinational sel/norm/abnorm for one lane, instantiated NUM_DIGITS times with a generate loop.
- The counters, pipeline and capture logic stay in the top module.

Test Plan:
- Clean word: reset, then all lanes A = B = 0, in_Y = lane index, in_cor = lane index + 100, in_valid = 1.
  - Two cycles later: out lanes = index + 100, error = 00, lane_err = 0, counters unchanged.
  - One cycle earlier: both stg1 flags = 0.
- Single-lane error: lane 3 has A = 0, B = 2, all other lanes are clean.
  - Lane 3 out = in_Y[3], other lanes = in_cor.
  - error = 01, lane_err = 8'h08, cor_err_stg1 = 1 one cycle before out_valid.
  - cor_count increments by 1.
- Multi-lane and malfunction: lanes 1 and 5 have A ≠ B, giving error = 10. The next word has lane 2 A = 1, giving error = 11 and mal_err_stg1 high the cycle before. mal_count = 2.
- Bubbles and latency: PIPE_DEPTH = 4, alternating in_valid 1/0 with error words.
  - out_valid pattern is the in_valid pattern delayed by 4.
  - Invalid slots show error = 00 and do not count.
- Saturation and clear: CNT_WIDTH = 2, five corrected words, so cor_count holds at 3. Assert clr_counts together with a corrected output word, so cor_count = 0.
- Async reset mid-stream: assert reset between clock edges while words are in flight.
  - All outputs go to 0 immediately.
  - After release, out_valid = 0 until PIPE_DEPTH cycles after the first new valid word.
  - With EC_ERR_CAPTURE_EN, cap_valid is cleared.
